// File: rtl/ptr_reader_pkg.sv
// Shared constants for the PDP-6 paper-tape reader (device 104).
// IO bus words are numbered [0:35] with bit 0 as the MSB, as on the machine.
package ptr_reader_pkg;

  // Device select code for the reader, as it appears on iobus_ios[3:9].
  localparam logic [6:0] DEV_PTR = 7'b0010001;

  // Default tape motion time, in idle clocks, after each accepted frame.
  localparam int FRAME_GAP_DEF = 4;

  // CONO / CONI field positions in the [0:35] bus word.
  localparam int BIT_DONE   = 30;
  localparam int BIT_BUSY   = 31;
  localparam int BIT_BINARY = 32;
  localparam int BIT_PIA_HI = 33;
  localparam int BIT_PIA_LO = 35;

  // Hole 8 marks a data frame in binary mode.
  localparam logic [7:0] FRAME_HOLE8 = 8'h80;

  typedef logic [0:35] io_word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GAP
  } dp_state_t;

  // Status word as returned by CONI.
  function automatic io_word_t coni_word(input logic done, input logic busy,
                                         input logic binary, input logic [2:0] pia);
    io_word_t w;
    w = '0;
    w[BIT_DONE]              = done;
    w[BIT_BUSY]              = busy;
    w[BIT_BINARY]            = binary;
    w[BIT_PIA_HI:BIT_PIA_LO] = pia;
    return w;
  endfunction

endpackage

// File: rtl/ptr_reader_if.sv
// IO bus slice seen by the reader plus the host-side tape frame stream.
interface ptr_reader_if;
  logic        iobus_iob_reset;
  logic [3:9]  iobus_ios;
  logic        iobus_datai;
  logic        iobus_status;
  logic        iobus_cono_clear;
  logic        iobus_cono_set;
  logic [0:35] iobus_iob_in;
  logic [0:35] iobus_iob_out;
  logic [1:7]  iobus_pi_req;
  logic        frame_valid;
  logic [7:0]  frame_data;
  logic        frame_ready;

  // Device side.
  modport slave (
    input  iobus_iob_reset, iobus_ios, iobus_datai, iobus_status,
           iobus_cono_clear, iobus_cono_set, iobus_iob_in,
           frame_valid, frame_data,
    output iobus_iob_out, iobus_pi_req, frame_ready
  );

  // Processor / host side.
  modport master (
    output iobus_iob_reset, iobus_ios, iobus_datai, iobus_status,
           iobus_cono_clear, iobus_cono_set, iobus_iob_in,
           frame_valid, frame_data,
    input  iobus_iob_out, iobus_pi_req, frame_ready
  );
endinterface

// File: rtl/ptr_word_asm.sv
// Word assembly: alphanumeric frames load directly, binary hole-8 frames
// shift in six bits at a time. complete flags the frame that finishes a word.
module ptr_word_asm
  import ptr_reader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic       binary,
  input  logic [7:0] frame,
  output io_word_t   word,
  output logic       complete
);

  logic [2:0] fcnt;
  logic       hole8;

  assign hole8    = (frame & FRAME_HOLE8) != 8'h00;
  assign complete = load && (!binary || (hole8 && fcnt == 3'd5));

  // Shift register and frame count; binary frames without hole 8 are dropped.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      word <= '0;
      fcnt <= '0;
    end else if (load) begin
      if (!binary) begin
        word <= {28'b0, frame};
      end else if (hole8) begin
        word <= {word[6:35], frame[5:0]};
        fcnt <= (fcnt == 3'd5) ? 3'd0 : fcnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/ptr_reader.sv
// PDP-6 paper-tape reader: IO bus decode, CONO/CONI flags, DATAI, PI request
// and the frame pacing state machine around the word assembler.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   S_IDLE | busy=0, gap=0: no word requested, frames held off
//   S_WAIT | busy=1, gap=0: frame_ready, next frame accepted
//   S_GAP  | gap!=0: tape in motion, gap counter runs down to 0
module ptr_reader
  import ptr_reader_pkg::*;
#(
  parameter logic [6:0] DEV_SEL   = DEV_PTR,
  parameter int         FRAME_GAP = FRAME_GAP_DEF
) (
  input  logic         clk,
  input  logic         reset,
  ptr_reader_if.slave  bus
);

  localparam logic [7:0] GAP_LOAD = 8'(FRAME_GAP);

  logic       sel, io_rst, live;
  logic       s_clear, s_set, s_datai, strobe;
  logic       accept, word_done, asm_clear;
  logic [2:0] pia_q, pia_n;
  logic       binary_q, binary_n;
  logic       busy_q, busy_n;
  logic       done_q, done_n;
  logic [7:0] gap_q, gap_n;
  logic [1:7] pi_q, pi_n;
  dp_state_t  state_q, state_n;
  io_word_t   word;
  logic       unused_iob;

  assign sel     = bus.iobus_ios == DEV_SEL;
  assign io_rst  = bus.iobus_iob_reset;
  assign live    = reset && !io_rst;
  assign s_clear = sel && bus.iobus_cono_clear;
  assign s_set   = sel && bus.iobus_cono_set;
  assign s_datai = sel && bus.iobus_datai;
  assign strobe  = s_clear || s_set || s_datai;

  // Only the low six CONO bits carry reader state.
  assign unused_iob = ^bus.iobus_iob_in[0:29];

  assign bus.frame_ready  = live && (state_q == S_WAIT) && !strobe;
  assign accept           = bus.frame_valid && bus.frame_ready;
  assign bus.iobus_pi_req = live ? pi_q : '0;

  ptr_word_asm u_asm (
    .clk      (clk),
    .reset    (reset),
    .clear    (asm_clear),
    .load     (accept),
    .binary   (binary_q),
    .frame    (bus.frame_data),
    .word     (word),
    .complete (word_done)
  );

  // Next flags, gap count and state, applied in bus priority order.
  always_comb begin
    pia_n     = pia_q;
    binary_n  = binary_q;
    busy_n    = busy_q;
    done_n    = done_q;
    gap_n     = (gap_q != 8'd0) ? gap_q - 8'd1 : gap_q;
    asm_clear = 1'b0;
    if (io_rst) begin
      pia_n     = '0;
      binary_n  = 1'b0;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      gap_n     = '0;
      asm_clear = 1'b1;
    end else if (s_clear) begin
      pia_n     = '0;
      binary_n  = 1'b0;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      gap_n     = '0;
      asm_clear = 1'b1;
    end else if (s_set) begin
      pia_n    = pia_q | bus.iobus_iob_in[BIT_PIA_HI:BIT_PIA_LO];
      binary_n = binary_q | bus.iobus_iob_in[BIT_BINARY];
      busy_n   = busy_q | bus.iobus_iob_in[BIT_BUSY];
      done_n   = done_q | bus.iobus_iob_in[BIT_DONE];
      // A fresh request starts a clean word.
      if (!busy_q && bus.iobus_iob_in[BIT_BUSY]) asm_clear = 1'b1;
    end else if (s_datai) begin
      done_n    = 1'b0;
      busy_n    = 1'b1;
      asm_clear = 1'b1;
    end else if (accept) begin
      gap_n = GAP_LOAD;
      if (word_done) begin
        done_n = 1'b1;
        busy_n = 1'b0;
      end
    end
    if (gap_n != 8'd0)
      state_n = S_GAP;
    else if (busy_n)
      state_n = S_WAIT;
    else
      state_n = S_IDLE;
    // PI follows the current flags, so it lags done by one clock.
    for (int i = 1; i <= 7; i++)
      pi_n[i] = done_q && (pia_q == 3'(i));
  end

  // Flag, gap, state and PI registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pia_q    <= '0;
      binary_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gap_q    <= '0;
      state_q  <= S_IDLE;
      pi_q     <= '0;
    end else begin
      pia_q    <= pia_n;
      binary_q <= binary_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      gap_q    <= gap_n;
      state_q  <= state_n;
      pi_q     <= io_rst ? '0 : pi_n;
    end
  end

  // DATAI returns the word, CONI the flags; the bus is 0 otherwise.
  always_comb begin
    bus.iobus_iob_out = '0;
    if (live) begin
      if (s_datai)
        bus.iobus_iob_out = word;
      else if (sel && bus.iobus_status)
        bus.iobus_iob_out = coni_word(done_q, busy_q, binary_q, pia_q);
    end
  end

endmodule

// File: tb/tb_ptr_reader.sv
// Bench for ptr_reader: directed scenarios followed by random bus/frame traffic,
// with DATAI/CONI results checked by a scoreboard monitor.
module tb_ptr_reader;

  localparam logic [6:0] DEV = 7'b0010001;
  localparam logic [6:0] BAD = 7'b0010010;
  localparam int         GAP = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ptr_reader_if bus ();

  ptr_reader #(.DEV_SEL(DEV), .FRAME_GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [35:0] val;
    int          kind;
  } exp_t;
  exp_t exp_q[$];

  // Reference model of the programmer-visible reader state.
  logic [2:0]  m_pia;
  logic        m_binary, m_busy, m_done;
  logic [35:0] m_word;
  int          m_fcnt;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %o, expected %o at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] model_coni();
    return {30'b0, m_done, m_busy, m_binary, m_pia};
  endfunction

  function automatic logic [6:0] model_pi();
    if (m_done && m_pia != 3'd0) return 7'b1000000 >> (m_pia - 3'd1);
    return 7'b0;
  endfunction

  task automatic model_reset();
    m_pia = '0; m_binary = 0; m_busy = 0; m_done = 0; m_word = '0; m_fcnt = 0;
  endtask

  task automatic model_frame(input logic [7:0] f);
    if (!m_binary) begin
      m_word = 36'(f);
      m_done = 1; m_busy = 0;
    end else if (f >= 8'd128) begin
      m_word = m_word * 64 + 36'(f % 64);
      m_fcnt = m_fcnt + 1;
      if (m_fcnt == 6) begin
        m_done = 1; m_busy = 0; m_fcnt = 0;
      end
    end
  endtask

  // Scoreboard monitor: every selected-or-not DATAI/CONI strobe consumes one expectation.
  always @(negedge clk) begin
    if (bus.iobus_datai === 1'b1 || bus.iobus_status === 1'b1) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_read: got %o, expected no read", bus.iobus_iob_out);
      end else begin
        e = exp_q.pop_front();
        check(e.kind == 0 ? "datai" : "coni", bus.iobus_iob_out, e.val);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic bus_idle();
    bus.iobus_iob_reset = 0; bus.iobus_ios = 7'b0; bus.iobus_datai = 0;
    bus.iobus_status = 0; bus.iobus_cono_clear = 0; bus.iobus_cono_set = 0;
    bus.iobus_iob_in = '0;
  endtask

  task automatic coni_read(input logic [6:0] ios, input logic [35:0] exp);
    bus.iobus_ios = ios; bus.iobus_status = 1;
    exp_q.push_back('{val: exp, kind: 1});
    step();
    bus_idle();
  endtask

  task automatic datai_read(input logic [35:0] exp);
    bus.iobus_ios = DEV; bus.iobus_datai = 1;
    exp_q.push_back('{val: exp, kind: 0});
    step();
    bus_idle();
    m_done = 0; m_busy = 1; m_word = '0; m_fcnt = 0;
  endtask

  task automatic bad_datai();
    bus.iobus_ios = BAD; bus.iobus_datai = 1;
    exp_q.push_back('{val: 36'b0, kind: 0});
    step();
    bus_idle();
  endtask

  // CONO as the processor issues it: clear, then set.
  task automatic cono(input logic [35:0] v);
    bus.iobus_ios = DEV; bus.iobus_cono_clear = 1;
    step();
    bus.iobus_cono_clear = 0; bus.iobus_cono_set = 1; bus.iobus_iob_in = v;
    step();
    bus_idle();
    model_reset();
    m_pia = v[2:0]; m_binary = v[3]; m_busy = v[4]; m_done = v[5];
  endtask

  task automatic bad_cono(input logic [35:0] v);
    bus.iobus_ios = BAD; bus.iobus_cono_clear = 1; bus.iobus_cono_set = 1;
    bus.iobus_iob_in = v;
    step();
    bus_idle();
  endtask

  task automatic check_pi(input logic [6:0] exp);
    step();
    @(negedge clk);
    check("pi_req", {29'b0, bus.iobus_pi_req}, {29'b0, exp});
    step();
  endtask

  task automatic send_frame(input logic [7:0] f);
    logic rdy;
    int   n;
    bus.frame_valid = 1; bus.frame_data = f; n = 0;
    do begin
      @(negedge clk); rdy = bus.frame_ready;
      @(posedge clk); n++;
    end while (!rdy && n < 40);
    #1;
    bus.frame_valid = 0;
    if (!rdy) check("frame_accept_timeout", 36'd0, 36'd1);
    else model_frame(f);
  endtask

  task automatic iob_reset_pulse();
    bus.iobus_iob_reset = 1; bus.iobus_ios = DEV; bus.iobus_status = 1;
    exp_q.push_back('{val: 36'b0, kind: 1});
    @(negedge clk);
    check("iob_reset_frame_ready", {35'b0, bus.frame_ready}, 36'd0);
    check("iob_reset_pi_req", {29'b0, bus.iobus_pi_req}, 36'd0);
    step();
    bus_idle();
    model_reset();
  endtask

  initial begin
    int acc[$];
    int lows;
    bus_idle();
    bus.frame_valid = 0; bus.frame_data = '0;
    model_reset();
    step(); step();
    reset = 1;

    // Hardware reset in the middle of a binary word.
    cono(36'o33);
    send_frame(8'o201); send_frame(8'o202); send_frame(8'o203);
    repeat (GAP + 2) step();
    reset = 0; bus.iobus_ios = DEV; bus.iobus_status = 1;
    exp_q.push_back('{val: 36'b0, kind: 1});
    @(negedge clk);
    check("reset_frame_ready", {35'b0, bus.frame_ready}, 36'd0);
    check("reset_pi_req", {29'b0, bus.iobus_pi_req}, 36'd0);
    step();
    bus_idle();
    step();
    reset = 1;
    model_reset();
    coni_read(DEV, 36'o0);
    check_pi(7'b0);
    datai_read(36'o0);

    // Binary word with a skipped no-hole-8 frame.
    cono(36'o33);
    send_frame(8'o201); send_frame(8'o005); send_frame(8'o202);
    send_frame(8'o203); send_frame(8'o204); send_frame(8'o205); send_frame(8'o206);
    coni_read(DEV, 36'o53);
    check_pi(7'b0010000);
    datai_read(36'o010203040506);
    @(negedge clk);
    check("pi_req_lag", {29'b0, bus.iobus_pi_req}, {29'b0, 7'b0010000});
    step();
    coni_read(DEV, 36'o33);
    check_pi(7'b0);

    // Alphanumeric word.
    cono(36'o21);
    send_frame(8'o215);
    check_pi(7'b1000000);
    datai_read(36'o215);
    check_pi(7'b0);

    // Frame pacing with frame_valid held high.
    cono(36'o33);
    bus.frame_valid = 1; bus.frame_data = 8'o201; lows = 0;
    for (int c = 0; c < 80 && acc.size() < 6; c++) begin
      @(negedge clk);
      if (bus.frame_ready) begin
        if (acc.size() > 0) begin
          check("pace_spacing", 36'(c - acc[acc.size() - 1]), 36'(GAP + 1));
          check("pace_low_cycles", 36'(lows), 36'(GAP));
        end
        acc.push_back(c);
        lows = 0;
      end else begin
        lows++;
      end
      @(posedge clk);
    end
    #1;
    bus.frame_valid = 0;
    check("pace_accepts", 36'(acc.size()), 36'd6);
    for (int i = 0; i < acc.size(); i++) model_frame(8'o201);
    datai_read(36'o010101010101);

    // Wrong select code.
    bad_datai();
    bad_cono(36'o77);
    coni_read(BAD, 36'o0);
    coni_read(DEV, model_coni());

    // IO reset after three binary frames, then a clean word.
    cono(36'o33);
    send_frame(8'o201); send_frame(8'o202); send_frame(8'o203);
    repeat (GAP + 2) step();
    iob_reset_pulse();
    coni_read(DEV, 36'o0);
    check_pi(7'b0);
    cono(36'o33);
    send_frame(8'o241); send_frame(8'o242); send_frame(8'o243);
    send_frame(8'o244); send_frame(8'o245); send_frame(8'o246);
    coni_read(DEV, 36'o53);
    datai_read(36'o414243444546);

    // Random traffic against the model.
    for (int i = 0; i < 250; i++) begin
      int op;
      logic [35:0] v;
      op = $urandom_range(0, 11);
      v = 36'({$urandom, $urandom});
      case (op)
        0, 1: cono(v);
        2, 3, 4, 5: begin
          if (m_busy) begin
            logic [7:0] f;
            f = 8'($urandom);
            if ($urandom_range(0, 3) != 0) f[7] = 1'b1;
            send_frame(f);
          end else begin
            coni_read(DEV, model_coni());
          end
        end
        6: datai_read(m_word);
        7: coni_read(DEV, model_coni());
        8: check_pi(model_pi());
        9: bad_datai();
        10: bad_cono(v);
        default: iob_reset_pulse();
      endcase
    end
    coni_read(DEV, model_coni());

    repeat (3) step();
    check("scoreboard_drain", 36'(exp_q.size()), 36'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
